// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: scan states,
// blank pattern and the active-high hex glyph set {g,f,e,d,c,b,a}.
package seg_scan_driver_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      4'hA:    glyph = GLYPH_A;
      4'hB:    glyph = GLYPH_B;
      4'hC:    glyph = GLYPH_C;
      4'hD:    glyph = GLYPH_D;
      4'hE:    glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Hex nibble to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module seg_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_glyph(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with blank gap, leading-zero
// blanking and frame-synchronous display update.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYCLES   = 64,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   digit_en_i,
  input  logic                  lzb_en_i,
  input  logic                  load_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   sel_o,
  output logic                  frame_o
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]    CNT_SHOW = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] SEL_OFF  = {N_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [6:0]          SEG_OFF  = {7{SEG_ACTIVE_LOW}};

  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_driver: N_DIGITS must be in 1..8");
  end
  if (DIV < 2) begin : g_bad_div
    $error("seg_scan_driver: CLK_HZ/SCAN_HZ must be at least 2");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIV) begin : g_bad_blank
    $error("seg_scan_driver: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DIV");
  end

  scan_state_e            state_reg, state_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic [IDX_W-1:0]       index_reg, index_next;

  logic [4*N_DIGITS-1:0]  stage_data_reg, active_data_reg;
  logic [N_DIGITS-1:0]    stage_dp_reg, active_dp_reg;
  logic                   pending_reg;
  logic                   frame_reg;

  logic [N_DIGITS-1:0]    sel_reg, sel_next;
  logic [6:0]             seg_reg, seg_next;
  logic                   dp_reg, dp_next;

  logic                   count_wrap;
  logic                   frame_edge;
  logic [N_DIGITS-1:0][3:0] active_nib;
  logic [N_DIGITS-1:0]    lz;
  logic [N_DIGITS-1:0]    lit;
  logic [N_DIGITS-1:0]    sel_hot;
  logic                   show_now;
  logic [3:0]             cur_nibble;
  logic [6:0]             cur_glyph;

  assign count_wrap = (count_reg == CNT_LAST);
  assign frame_edge = count_wrap && (index_reg == IDX_LAST);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg + CNT_W'(1);
    index_next = index_reg;
    if (count_wrap) begin
      count_next = '0;
      index_next = (index_reg == IDX_LAST) ? '0 : index_reg + IDX_W'(1);
    end
    case (state_reg)
      BLANK:   if (count_next == CNT_SHOW) state_next = SHOW;
      SHOW:    if (count_wrap) state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= BLANK;
      count_reg <= '0;
      index_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      index_reg <= index_next;
    end
  end

  // Staged values only reach the displayed register at the frame boundary,
  // so a frame never mixes old and new digits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_data_reg  <= '0;
      stage_dp_reg    <= '0;
      active_data_reg <= '0;
      active_dp_reg   <= '0;
      pending_reg     <= 1'b0;
      frame_reg       <= 1'b0;
    end else begin
      frame_reg <= frame_edge && pending_reg;
      if (load_i) begin
        stage_data_reg <= data_i;
        stage_dp_reg   <= dp_i;
      end
      if (frame_edge && pending_reg) begin
        active_data_reg <= stage_data_reg;
        active_dp_reg   <= stage_dp_reg;
      end
      if (load_i) begin
        pending_reg <= 1'b1;
      end else if (frame_edge) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign active_nib = active_data_reg;

  // A digit is a leading zero when it and every more significant nibble are 0.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    if (gi == 0) begin : g_lsd
      assign lz[gi] = 1'b0;
    end else begin : g_upper
      assign lz[gi] = lzb_en_i && (active_data_reg[4*N_DIGITS-1:4*gi] == '0);
    end
    assign lit[gi]     = digit_en_i[gi] && !lz[gi];
    assign sel_hot[gi] = show_now && (index_reg == IDX_W'(gi));
  end

  assign show_now   = (state_reg == SHOW) && lit[index_reg];
  assign cur_nibble = active_nib[index_reg];

  seg_decode u_decode (
    .nibble (cur_nibble),
    .seg    (cur_glyph)
  );

  always_comb begin
    sel_next = sel_hot ^ SEL_OFF;
    seg_next = (show_now ? cur_glyph : SEG_BLANK) ^ SEG_OFF;
    dp_next  = (show_now && active_dp_reg[index_reg]) ^ SEG_ACTIVE_LOW;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_reg <= SEL_OFF;
      seg_reg <= SEG_OFF;
      dp_reg  <= SEG_ACTIVE_LOW;
    end else begin
      sel_reg <= sel_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign sel_o   = sel_reg;
  assign seg_o   = seg_reg;
  assign dp_o    = dp_reg;
  assign frame_o = frame_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: DIV=10, BLANK_CYCLES=2, 4 digits,
// active-low selects and segments.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  en = 4'hF;
  logic        lzb = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dpo;
  logic [3:0]  sel;
  logic        frame;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .N_DIGITS       (4),
    .CLK_HZ         (1000),
    .SCAN_HZ        (100),
    .BLANK_CYCLES   (2),
    .SEL_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .data_i     (data),
    .dp_i       (dp_in),
    .digit_en_i (en),
    .lzb_en_i   (lzb),
    .load_i     (load),
    .seg_o      (seg),
    .dp_o       (dpo),
    .sel_o      (sel),
    .frame_o    (frame)
  );

  typedef struct {
    logic [15:0]      data;
    logic [3:0]       dp;
    logic [3:0]       en;
    logic             lzb;
    logic [3:0][3:0]  exp_sel;
    logic [3:0][6:0]  exp_seg;
    logic [3:0]       exp_dp;
  } vec_t;

  vec_t vecs [6];
  vec_t v_zero, v_1234, v_00a0, v_5678;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data  = d;
    dp_in = p;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
  endtask

  task automatic wait_frame(input int limit, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick(1);
      if (frame === 1'b1) seen = 1'b1;
    end
    check({tag, " frame pulse seen"}, {15'd0, seen}, 16'd1);
  endtask

  // Call at the cycle where the scan sits at count 0 of digit 0; returns 40
  // cycles later at the start of the following frame.
  task automatic check_frame(input vec_t v, input string tag);
    logic [11:0] e;
    int pulses;
    pulses = 0;
    for (int j = 1; j <= 40; j++) begin
      int c;
      int k;
      tick(1);
      c = (j - 1) % 10;
      k = (j - 1) / 10;
      if (c < 2) e = {4'hF, 7'h7F, 1'b1};
      else       e = {v.exp_sel[k], v.exp_seg[k], v.exp_dp[k]};
      check($sformatf("%s j=%0d {sel,seg,dp}", tag, j), {4'd0, sel, seg, dpo}, {4'd0, e});
      if (j < 40 && frame === 1'b1) pulses++;
    end
    check({tag, " no frame pulse mid-frame"}, 16'(pulses), 16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    v_zero  = '{16'h0000, 4'b0000, 4'hF, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
    v_1234  = '{16'h1234, 4'b0000, 4'hF, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    v_00a0  = '{16'h00A0, 4'b0000, 4'hF, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h40, 7'h40, 7'h08, 7'h40}, 4'b1111};
    v_5678  = '{16'h5678, 4'b0100, 4'hF, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1011};

    vecs[0] = v_1234;
    vecs[1] = '{16'h0000, 4'b0000, 4'hF, 1'b1, {4'hF, 4'hF, 4'hF, 4'b1110},
                {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vecs[2] = '{16'h0050, 4'b0000, 4'hF, 1'b1, {4'hF, 4'hF, 4'b1101, 4'b1110},
                {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    vecs[3] = '{16'h89EF, 4'b0101, 4'b1010, 1'b0, {4'b0111, 4'hF, 4'b1101, 4'hF},
                {7'h00, 7'h7F, 7'h06, 7'h7F}, 4'b1111};
    vecs[4] = '{16'h4CD7, 4'b0100, 4'hF, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h19, 7'h46, 7'h21, 7'h78}, 4'b1011};
    vecs[5] = '{16'h0B06, 4'b1111, 4'hF, 1'b1, {4'hF, 4'b1011, 4'b1101, 4'b1110},
                {7'h7F, 7'h03, 7'h40, 7'h02}, 4'b1000};

    // Reset state and the power-up scan of an all-zero display.
    #2 rst = 1'b1;
    tick(3);
    check("reset sel", {12'd0, sel}, 16'h000F);
    check("reset seg", {9'd0, seg}, 16'h007F);
    check("reset dp", {15'd0, dpo}, 16'd1);
    check("reset frame", {15'd0, frame}, 16'd0);
    rst = 1'b0;
    check_frame(v_zero, "post_reset");
    $display("[TB] post-reset scan of 0000 checked");

    for (int i = 0; i < 6; i++) begin
      en  = vecs[i].en;
      lzb = vecs[i].lzb;
      do_load(vecs[i].data, vecs[i].dp);
      wait_frame(100, $sformatf("vec%0d", i));
      check_frame(vecs[i], $sformatf("vec%0d", i));
      $display("[TB] vec%0d data=%h dp=%b en=%b lzb=%b checked",
               i, vecs[i].data, vecs[i].dp, vecs[i].en, vecs[i].lzb);
    end
    en  = 4'hF;
    lzb = 1'b0;

    // Mid-frame load: the old value stays until the frame boundary.
    do_load(16'h1234, 4'b0000);
    wait_frame(100, "A_setup");
    check_frame(v_1234, "A_setup");
    tick(15);
    do_load(16'h00A0, 4'b0000);
    pulses = 0;
    for (int j = 17; j <= 40; j++) begin
      tick(1);
      if (j == 26) check("A hold digit2", {5'd0, sel, seg}, {5'd0, 4'b1011, 7'h24});
      if (j == 36) check("A hold digit3", {5'd0, sel, seg}, {5'd0, 4'b0111, 7'h79});
      if (j < 40 && frame === 1'b1) pulses++;
    end
    check("A no early frame pulse", 16'(pulses), 16'd0);
    check("A frame pulse at boundary", {15'd0, frame}, 16'd1);
    check_frame(v_00a0, "A_new");
    $display("[TB] mid-frame load of 00A0 checked");

    // Load landing exactly on the boundary cycle waits one full frame.
    tick(39);
    do_load(16'h5678, 4'b0100);
    check("B no pulse after boundary load", {15'd0, frame}, 16'd0);
    check_frame(v_00a0, "B_hold");
    check("B frame pulse one frame later", {15'd0, frame}, 16'd1);
    check_frame(v_5678, "B_new");
    $display("[TB] boundary-cycle load of 5678 checked");

    // Asynchronous reset in the middle of a lit slot.
    tick(5);
    check("C lit before reset", {12'd0, sel}, 16'h000E);
    rst = 1'b1;
    #1;
    check("C async sel", {12'd0, sel}, 16'h000F);
    check("C async seg", {9'd0, seg}, 16'h007F);
    check("C async dp", {15'd0, dpo}, 16'd1);
    tick(2);
    rst = 1'b0;
    check_frame(v_zero, "C_restart");
    $display("[TB] mid-scan reset checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
